// File: rtl/sprite_palette_pkg.sv
// Shared types and constants for the double-buffered sprite palette controller.
package sprite_palette_pkg;

    localparam int PAL_NUM_ENTRIES = 16;
    localparam int PAL_IDX_W       = 4;
    localparam int PAL_CH_W        = 4;
    localparam int PAL_KEY_INDEX   = 0;

    typedef struct packed {
        logic [PAL_CH_W-1:0] r;
        logic [PAL_CH_W-1:0] g;
        logic [PAL_CH_W-1:0] b;
    } rgb_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_COPY  = 2'd2
    } commit_state_t;

    // Entry 0 is the magenta-ish colour key, everything else starts white.
    localparam logic [PAL_NUM_ENTRIES-1:0][3*PAL_CH_W-1:0] PAL_DEFAULT =
        {{(PAL_NUM_ENTRIES-1){12'hFFF}}, 12'hF0D};

endpackage

// File: rtl/sprite_palette_ctrl_scale.sv
// One colour channel scaled by (brightness + 1) / 16; used three times in S2.
module palette_fade_scale #(
    parameter int CH_W = 4
) (
    input  logic [CH_W-1:0] ch_i,
    input  logic [CH_W-1:0] bright_i,
    output logic [CH_W-1:0] scaled_o
);

    logic [2*CH_W-1:0] prod;

    // Full-scale brightness must be the identity, hence +1 before the shift.
    assign prod     = (2*CH_W)'(ch_i) * ((2*CH_W)'(bright_i) + (2*CH_W)'(1));
    assign scaled_o = CH_W'(prod >> CH_W);

endmodule

// File: rtl/sprite_palette_ctrl.sv
// Double-buffered 16-entry sprite palette with vblank commit, per-frame fade
// and a 2-stage pipelined index-to-colour lookup.
module sprite_palette_ctrl
    import sprite_palette_pkg::*;
#(
    parameter int NUM_ENTRIES = PAL_NUM_ENTRIES,
    parameter int IDX_W       = PAL_IDX_W,
    parameter int CH_W        = PAL_CH_W,
    parameter int KEY_INDEX   = PAL_KEY_INDEX
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [IDX_W-1:0]  wr_index,
    input  logic [3*CH_W-1:0] wr_rgb,
    input  logic              commit_req,
    input  logic              frame_start,
    output logic              commit_pending,
    input  logic              fade_start,
    input  logic              fade_dir,
    output logic              fade_busy,
    input  logic              pix_valid_in,
    input  logic [IDX_W-1:0]  pix_index,
    output logic              pix_valid_out,
    output logic [CH_W-1:0]   red,
    output logic [CH_W-1:0]   green,
    output logic [CH_W-1:0]   blue,
    output logic              transparent
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ENTRIES - 1);
    localparam logic [CH_W-1:0]  BRIGHT_MAX = '1;

    logic [NUM_ENTRIES-1:0][3*CH_W-1:0] shadow_q;
    logic [NUM_ENTRIES-1:0][3*CH_W-1:0] active_q;

    commit_state_t    state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic             rearm_q, rearm_d;

    logic [CH_W-1:0]  bright_q, bright_d;
    logic             busy_q, busy_d;
    logic             dir_q, dir_d;

    logic [1:0]       vld_pipe_q;
    logic             s1_key_q;
    rgb_t             s1_rgb_q;
    rgb_t             out_rgb_q;
    logic             trans_q;
    rgb_t             scaled;

    assign wr_ready       = (state_q != ST_COPY);
    assign commit_pending = (state_q != ST_IDLE);
    assign fade_busy      = busy_q;

    // Commit FSM: arm on request, copy one entry per cycle from the next vblank.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        rearm_d = rearm_q;
        case (state_q)
            ST_IDLE: begin
                if (commit_req) state_d = ST_ARMED;
            end
            ST_ARMED: begin
                if (frame_start) begin
                    state_d = ST_COPY;
                    ptr_d   = '0;
                    rearm_d = 1'b0;
                end
            end
            ST_COPY: begin
                ptr_d = ptr_q + IDX_W'(1);
                if (commit_req) rearm_d = 1'b1;
                if (ptr_q == LAST_IDX) begin
                    state_d = (rearm_q || commit_req) ? ST_ARMED : ST_IDLE;
                    rearm_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            rearm_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            rearm_q <= rearm_d;
        end
    end

    // Writes are held off during the copy so active never sees a half-updated shadow.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            shadow_q <= PAL_DEFAULT;
            active_q <= PAL_DEFAULT;
        end else begin
            if (wr_valid && wr_ready) shadow_q[wr_index] <= wr_rgb;
            if (state_q == ST_COPY)   active_q[ptr_q]    <= shadow_q[ptr_q];
        end
    end

    // Fade: one brightness step per frame; a later fade_start overrides direction.
    always_comb begin
        bright_d = bright_q;
        busy_d   = busy_q;
        dir_d    = dir_q;
        if (frame_start && busy_q) begin
            if (dir_q) begin
                if (bright_q == BRIGHT_MAX) begin
                    busy_d = 1'b0;
                end else begin
                    bright_d = bright_q + CH_W'(1);
                    if (bright_q == BRIGHT_MAX - CH_W'(1)) busy_d = 1'b0;
                end
            end else begin
                if (bright_q == '0) begin
                    busy_d = 1'b0;
                end else begin
                    bright_d = bright_q - CH_W'(1);
                    if (bright_q == CH_W'(1)) busy_d = 1'b0;
                end
            end
        end
        if (fade_start) begin
            busy_d = 1'b1;
            dir_d  = fade_dir;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            bright_q <= BRIGHT_MAX;
            busy_q   <= 1'b0;
            dir_q    <= 1'b0;
        end else begin
            bright_q <= bright_d;
            busy_q   <= busy_d;
            dir_q    <= dir_d;
        end
    end

    palette_fade_scale #(.CH_W(CH_W)) u_scale_r (
        .ch_i(s1_rgb_q.r), .bright_i(bright_q), .scaled_o(scaled.r));
    palette_fade_scale #(.CH_W(CH_W)) u_scale_g (
        .ch_i(s1_rgb_q.g), .bright_i(bright_q), .scaled_o(scaled.g));
    palette_fade_scale #(.CH_W(CH_W)) u_scale_b (
        .ch_i(s1_rgb_q.b), .bright_i(bright_q), .scaled_o(scaled.b));

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            vld_pipe_q <= '0;
            s1_key_q   <= 1'b0;
            s1_rgb_q   <= '0;
            out_rgb_q  <= '0;
            trans_q    <= 1'b0;
        end else begin
            vld_pipe_q <= {vld_pipe_q[0], pix_valid_in};
            s1_key_q   <= (pix_index == IDX_W'(KEY_INDEX));
            s1_rgb_q   <= rgb_t'(active_q[pix_index]);
            if (vld_pipe_q[0]) out_rgb_q <= scaled;
            trans_q    <= vld_pipe_q[0] && s1_key_q;
        end
    end

    assign pix_valid_out = vld_pipe_q[1];
    assign red           = out_rgb_q.r;
    assign green         = out_rgb_q.g;
    assign blue          = out_rgb_q.b;
    assign transparent   = trans_q;

endmodule
